cmp_share_sched: RTL and testbench

//  Shares one 10-bit magnitude comparator among NREQ requesters, each supplying an (a,b) operand pair.

---
 rtl/cmp_share_sched_pkg.sv | 25 ++
 rtl/cmp_share_sched_rr_arb.sv | 29 ++
 rtl/cmp_share_sched.sv | 138 +++++++++++++
 tb/tb_cmp_share_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cmp_share_sched_pkg.sv
// Shared definitions for cmp_share_sched: FSM state encoding, default sizes and clog2.
// Optional feature macro used by the top: CMP_SHARE_SIGNED_EN.
package cmp_share_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_share_sched_rr_arb.sv
// Combinational round-robin arbiter: first set req at or above rr_ptr, wrapping to 0.
module cmp_share_sched_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = IDW'(idx);
                gnt_oh[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_sched.sv
// One shared WIDTH-bit comparator serving NREQ requesters with round-robin grant and tagged response.
// Macro CMP_SHARE_SIGNED_EN: defined -> signed ls/gr compare; undefined -> unsigned.
module cmp_share_sched
    import cmp_share_sched_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_eq,
    output logic                  rsp_ls,
    output logic                  rsp_gr
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic              rsp_eq_q, rsp_eq_d;
    logic              rsp_ls_q, rsp_ls_d;
    logic              rsp_gr_q, rsp_gr_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDW-1:0]    id_q, id_d;

    logic [NREQ-1:0]   arb_oh;
    logic [IDW-1:0]    arb_idx;
    logic              arb_vld;
    logic              cmp_eq, cmp_ls, cmp_gr;

    cmp_share_sched_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign cmp_eq = (a_q == b_q);
`ifdef CMP_SHARE_SIGNED_EN
    assign cmp_ls = ($signed(a_q) < $signed(b_q));
    assign cmp_gr = ($signed(a_q) > $signed(b_q));
`else
    assign cmp_ls = (a_q < b_q);
    assign cmp_gr = (a_q > b_q);
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_eq_d    = 1'b0;
        rsp_ls_d    = 1'b0;
        rsp_gr_d    = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        case (state_q)
            S_IDLE: begin
                if (arb_vld) begin
                    state_d  = S_BUSY;
                    gnt_d    = arb_oh;
                    busy_d   = 1'b1;
                    a_d      = a_in[int'(arb_idx)*WIDTH +: WIDTH];
                    b_d      = b_in[int'(arb_idx)*WIDTH +: WIDTH];
                    id_d     = arb_idx;
                    rr_ptr_d = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);
                end
            end
            S_BUSY: begin
                // req is not looked at here; the next grant waits for IDLE
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_eq_d    = cmp_eq;
                rsp_ls_d    = cmp_ls;
                rsp_gr_d    = cmp_gr;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_eq_q    <= 1'b0;
            rsp_ls_q    <= 1'b0;
            rsp_gr_q    <= 1'b0;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_ls_q    <= rsp_ls_d;
            rsp_gr_q    <= rsp_gr_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_ls    = rsp_ls_q;
    assign rsp_gr    = rsp_gr_q;

endmodule

// File: tb/tb_cmp_share_sched.sv
// Directed bench for cmp_share_sched (NREQ=4, WIDTH=10); honours CMP_SHARE_SIGNED_EN.
module tb_cmp_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 10;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic                  rsp_eq;
    logic                  rsp_ls;
    logic                  rsp_gr;

    int n_chk;
    int n_pass;

    cmp_share_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_ls    (rsp_ls),
        .rsp_gr    (rsp_gr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    // {gnt, busy, rsp_valid, rsp_id, eq, ls, gr}
    function automatic logic [31:0] outs();
        return 32'({gnt, busy, rsp_valid, rsp_id, rsp_eq, rsp_ls, rsp_gr});
    endfunction

    logic [NREQ-1:0] rot_exp [5];
    logic [1:0]      rot_id  [5];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        req    = '0;
        a_in   = '0;
        b_in   = '0;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs", outs(), 32'h0);
        end

        // single request, a<b
        set_ops(1, 10'd5, 10'd9);
        req = 4'b0010;
        tick();
        check("t2_gnt", 32'(gnt), 32'h2);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_rv_early", 32'(rsp_valid), 32'h0);
        req = 4'b0000;
        tick();
        check("t2_rsp", outs(), 32'({4'b0000, 1'b0, 1'b1, 2'd1, 3'b010}));

        // strict rotation from rr_ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 10'h155, 10'h155);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rot_gnt", 32'(gnt), 32'(rot_exp[i]));
            tick();
            check("rot_rsp", outs(), 32'({4'b0000, 1'b0, 1'b1, rot_id[i], 3'b100}));
        end

        // grant to 2, then 1001 -> 3 then 0
        req = 4'b0100;
        tick();
        check("skip_g2", 32'(gnt), 32'h4);
        req = 4'b1001;
        tick();
        check("skip_r2", 32'(rsp_id), 32'h2);
        tick();
        check("skip_g3", 32'(gnt), 32'h8);
        tick();
        check("skip_r3", 32'(rsp_id), 32'h3);
        tick();
        check("skip_g0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("skip_r0", outs(), 32'({4'b0000, 1'b0, 1'b1, 2'd0, 3'b100}));

        // 0x3FF vs 0x000
        set_ops(0, 10'h3FF, 10'h000);
        req = 4'b0001;
        tick();
        check("sgn_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
`ifdef CMP_SHARE_SIGNED_EN
        check("sgn_cmp", 32'({rsp_valid, rsp_eq, rsp_ls, rsp_gr}), 32'b1010);
`else
        check("sgn_cmp", 32'({rsp_valid, rsp_eq, rsp_ls, rsp_gr}), 32'b1001);
`endif

        // reset while BUSY discards the compare and clears rr_ptr
        set_ops(2, 10'd1, 10'd2);
        req = 4'b0100;
        tick();
        check("mid_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        check("mid_outs", outs(), 32'h0);
        rst = 1'b0;
        tick();
        check("mid_quiet", outs(), 32'h0);
        req = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("post_rst_rsp", 32'({rsp_valid, rsp_id}), 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
